hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes decoded control already carried down the pipe by the control unit: rd_wren, wb_sel (load = 2'b10) and the EX-stage br_sel.
- Drives per-stage register enables, flushes and EX-operand forwarding selects.
- Freezes the pipe while data memory is busy, with a timeout error. Keeps stall and flush performance counters.

Parameters:
- TIMEOUT, 255, max consecutive cycles a MEM-stage access may wait for mem_ack_i before error.
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- id_rs1_i, id_rs2_i  in  5 each  ID-stage source registers
- id_rs1_use_i, id_rs2_use_i  in  1 each  ID instruction reads rs1 / rs2
- ex_rs1_i, ex_rs2_i  in  5 each  EX-stage source registers
- ex_rd_i  in  5  EX destination
- ex_rd_wren_i  in  1  EX destination write enable
- ex_is_load_i  in  1  EX instruction is a load
- ex_br_taken_i  in  1  EX branch/jump redirect (br_sel)
- mem_rd_i  in  5  MEM destination
- mem_rd_wren_i  in  1  MEM destination write enable
- wb_rd_i  in  5  WB destination
- wb_rd_wren_i  in  1  WB destination write enable
- mem_req_i  in  1  MEM stage holds a load/store
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o  out  1 each  stage register enables
- ifid_flush_o, idex_flush_o  out  1 each  insert bubble (synchronous clear) into IF/ID, ID/EX
- fwd_a_o, fwd_b_o  out  2 each  EX operand source: 00 regfile, 01 MEM ALU result, 10 WB data
- mem_err_o  out  1  sticky memory timeout error
- stall_cnt_o  out  CNT_W  cycles with pc_en_o=0 while not in ERR
- flush_cnt_o  out  CNT_W  taken-redirect flush events

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low.
- Reset: state=RUN, wait_cnt=0, stall_cnt_o=0, flush_cnt_o=0, mem_err_o=0. All other outputs are combinational from state and inputs.
- FSM states:
  - RUN → WAIT when mem_req_i && !mem_ack_i.
  - WAIT → RUN on mem_ack_i.
  - WAIT → ERR when wait_cnt reaches TIMEOUT with no ack.
  - ERR is sticky until reset.
- wait_cnt: cleared in RUN, increments each WAIT cycle.
- Forwarding (always evaluated, independent of state), per operand:
  - 01 if mem_rd_wren_i && mem_rd_i!=0 && mem_rd_i==ex_rsX_i.
  - Else 10 if wb_rd_wren_i && wb_rd_i!=0 && wb_rd_i==ex_rsX_i.
  - Else 00. MEM has priority over WB; x0 is never forwarded.
- Priority per cycle, highest first:
  1. ERR, or memory busy (mem_req_i && !mem_ack_i in RUN or WAIT): all five enables 0, no flushes.
  2. Taken redirect (ex_br_taken_i): all enables 1, ifid_flush_o=1, idex_flush_o=1. This is a 2-bubble penalty. flush_cnt_o increments.
  3. Load-use: ex_is_load_i && ex_rd_wren_i && ex_rd_i!=0 && ex_rd_i matches a used ID source. Then pc_en_o=0, ifid_en_o=0, idex_flush_o=1, other enables 1. This is exactly one bubble; the consumer later forwards via 10.
  4. Otherwise all enables 1, no flushes.
- Redirect during WAIT: EX is frozen, so ex_br_taken_i stays high. The flush is applied in the cycle mem_ack_i arrives and is counted once.
- Ack in the same cycle as the request: no stall; state stays RUN.
- stall_cnt_o increments on every non-ERR cycle with pc_en_o=0 (memory wait and load-use).
- Both counters saturate at all-ones and do not wrap.
- Flush outputs are never asserted while any enable is forced 0 by priority 1.

Decomposition:
- hazard_ctrl_pkg holds:
  - state enum: RUN, WAIT, ERR
  - forwarding constants: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
- One sub-module: fwd_unit, the combinational forwarding compare, instantiated once per operand.
- FSM, priority logic and counters stay in hazard_ctrl.

Test Plan:
- Load-use: `lw x5` in EX (ex_is_load_i=1, ex_rd_i=5), ID has rs1=5 used → one cycle with pc_en_o=0, ifid_en_o=0, idex_flush_o=1. Next cycle (load in WB, ex_rs1_i=5, wb_rd_i=5) fwd_a_o=10; stall_cnt_o=1.
- Forward priority: mem_rd_i=wb_rd_i=ex_rs2_i=7, both wren=1 → fwd_b_o=01. Repeat with rd=0 → fwd_b_o=00.
- Taken branch: ex_br_taken_i=1 → ifid_flush_o=idex_flush_o=1, pc_en_o=1. Also hold a load-use match the same cycle → no stall; flush_cnt_o=1.
- Memory wait: mem_req_i=1, mem_ack_i low for 3 cycles then high → enables 0 for 3 cycles, RUN on the 4th; stall_cnt_o=3. Ack same cycle as request → no stall.
- Timeout: TIMEOUT=4, ack never arrives → mem_err_o=1 after 4 WAIT cycles, all enables stay 0. Pulling rst_ni low for one clock restores RUN with counters 0.
- Redirect during WAIT: ex_br_taken_i=1 throughout a 2-cycle wait → no flush while waiting, one flush on the ack cycle; flush_cnt_o=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared types and constants for the RV32I pipeline hazard control.
// Revision : 1.0 - initial release
// =============================================================================
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // A producer only matters when it writes a real register (x0 is hardwired).
   function automatic logic src_match(
      input logic [4:0] rd,
      input logic       wren,
      input logic [4:0] rs
   );
      return wren && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
`default_nettype none
// =============================================================================
// Module   : fwd_unit
// Brief    : EX-operand bypass select for one source operand.
// Revision : 1.0 - initial release
// =============================================================================
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs_i,
   input  logic [4:0] mem_rd_i,
   input  logic       mem_rd_wren_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_rd_wren_i,
   output logic [1:0] fwd_sel_o
);

   logic w_hit_mem;
   logic w_hit_wb;

   assign w_hit_mem = src_match(mem_rd_i, mem_rd_wren_i, ex_rs_i);
   assign w_hit_wb  = src_match(wb_rd_i, wb_rd_wren_i, ex_rs_i);

   // The younger MEM result must win over the older WB value.
   always_comb begin
      fwd_sel_o = FWD_RF;
      if (w_hit_mem) begin
         fwd_sel_o = FWD_MEM;
      end else if (w_hit_wb) begin
         fwd_sel_o = FWD_WB;
      end
   end

endmodule : fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage pipeline sequencer: enables, flushes, forwarding, memory
//            wait/timeout FSM and saturating stall/flush counters.
// Revision : 1.0 - initial release
// =============================================================================
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_rs1_use_i,
   input  logic             id_rs2_use_i,
   input  logic [4:0]       ex_rs1_i,
   input  logic [4:0]       ex_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_rd_wren_i,
   input  logic             ex_is_load_i,
   input  logic             ex_br_taken_i,
   input  logic [4:0]       mem_rd_i,
   input  logic             mem_rd_wren_i,
   input  logic [4:0]       wb_rd_i,
   input  logic             wb_rd_wren_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             idex_en_o,
   output logic             exmem_en_o,
   output logic             memwb_en_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   // Wait counter only has to reach TIMEOUT-1; the transition to ERR happens
   // on the cycle that would make it TIMEOUT.
   localparam int                 c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

   state_e              r_state;
   logic [c_WAIT_W-1:0] r_wait_cnt;
   logic                r_mem_err;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic [CNT_W-1:0]    r_flush_cnt;

   logic w_mem_busy;
   logic w_freeze;
   logic w_load_use;
   logic w_pc_en;
   logic w_ifid_en;
   logic w_idex_en;
   logic w_exmem_en;
   logic w_memwb_en;
   logic w_ifid_flush;
   logic w_idex_flush;
   logic w_stall_evt;
   logic w_flush_evt;

   fwd_unit u_fwd_a (
      .ex_rs_i       (ex_rs1_i),
      .mem_rd_i      (mem_rd_i),
      .mem_rd_wren_i (mem_rd_wren_i),
      .wb_rd_i       (wb_rd_i),
      .wb_rd_wren_i  (wb_rd_wren_i),
      .fwd_sel_o     (fwd_a_o)
   );

   fwd_unit u_fwd_b (
      .ex_rs_i       (ex_rs2_i),
      .mem_rd_i      (mem_rd_i),
      .mem_rd_wren_i (mem_rd_wren_i),
      .wb_rd_i       (wb_rd_i),
      .wb_rd_wren_i  (wb_rd_wren_i),
      .fwd_sel_o     (fwd_b_o)
   );

   assign w_mem_busy = mem_req_i && !mem_ack_i;
   assign w_freeze   = (r_state == ERR) || w_mem_busy;
   assign w_load_use = ex_is_load_i &&
                       ((id_rs1_use_i && src_match(ex_rd_i, ex_rd_wren_i, id_rs1_i)) ||
                        (id_rs2_use_i && src_match(ex_rd_i, ex_rd_wren_i, id_rs2_i)));

   always_comb begin
      w_pc_en      = 1'b1;
      w_ifid_en    = 1'b1;
      w_idex_en    = 1'b1;
      w_exmem_en   = 1'b1;
      w_memwb_en   = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      if (w_freeze) begin
         w_pc_en    = 1'b0;
         w_ifid_en  = 1'b0;
         w_idex_en  = 1'b0;
         w_exmem_en = 1'b0;
         w_memwb_en = 1'b0;
      end else if (ex_br_taken_i) begin
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (w_load_use) begin
         // Hold IF and ID, push one bubble into EX.
         w_pc_en      = 1'b0;
         w_ifid_en    = 1'b0;
         w_idex_flush = 1'b1;
      end
   end

   assign pc_en_o      = w_pc_en;
   assign ifid_en_o    = w_ifid_en;
   assign idex_en_o    = w_idex_en;
   assign exmem_en_o   = w_exmem_en;
   assign memwb_en_o   = w_memwb_en;
   assign ifid_flush_o = w_ifid_flush;
   assign idex_flush_o = w_idex_flush;

   // A redirect held through a memory wait is only counted once it is applied.
   assign w_flush_evt = !w_freeze && ex_br_taken_i;
   assign w_stall_evt = (r_state != ERR) && !w_pc_en;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               r_wait_cnt <= '0;
               if (w_mem_busy) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (mem_ack_i) begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == c_WAIT_LAST) begin
                  r_state   <= ERR;
                  r_mem_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ERR: begin
               r_mem_err <= 1'b1;
            end
            default: begin
               r_state   <= ERR;
               r_mem_err <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_flush_evt && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign mem_err_o   = r_mem_err;
   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed plus random bench for hazard_ctrl against a cycle model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_hazard_ctrl;

   localparam int TO   = 4;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic          id_rs1_use, id_rs2_use, ex_rd_wren, ex_is_load, br;
   logic          mem_rd_wren, wb_rd_wren, mem_req, mem_ack;
   logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic          ifid_flush, idex_flush, mem_err;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit m_err, m_waiting;
   int m_waited, m_stall, m_flush;
   logic [6:0] e_ctl;
   logic [1:0] e_fa, e_fb;

   always #5 clk = ~clk;

   hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_rs1_use_i  (id_rs1_use),
      .id_rs2_use_i  (id_rs2_use),
      .ex_rs1_i      (ex_rs1),
      .ex_rs2_i      (ex_rs2),
      .ex_rd_i       (ex_rd),
      .ex_rd_wren_i  (ex_rd_wren),
      .ex_is_load_i  (ex_is_load),
      .ex_br_taken_i (br),
      .mem_rd_i      (mem_rd),
      .mem_rd_wren_i (mem_rd_wren),
      .wb_rd_i       (wb_rd),
      .wb_rd_wren_i  (wb_rd_wren),
      .mem_req_i     (mem_req),
      .mem_ack_i     (mem_ack),
      .pc_en_o       (pc_en),
      .ifid_en_o     (ifid_en),
      .idex_en_o     (idex_en),
      .exmem_en_o    (exmem_en),
      .memwb_en_o    (memwb_en),
      .ifid_flush_o  (ifid_flush),
      .idex_flush_o  (idex_flush),
      .fwd_a_o       (fwd_a),
      .fwd_b_o       (fwd_b),
      .mem_err_o     (mem_err),
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt)
   );

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (mem_rd_wren && mem_rd != 0 && mem_rd == rs) return 2'b01;
      if (wb_rd_wren && wb_rd != 0 && wb_rd == rs) return 2'b10;
      return 2'b00;
   endfunction

   // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}
   task automatic expect_now();
      logic lu;
      lu = ex_is_load && ex_rd_wren && ex_rd != 0 &&
           ((id_rs1_use && id_rs1 == ex_rd) || (id_rs2_use && id_rs2 == ex_rd));
      if (m_err || (mem_req && !mem_ack)) e_ctl = 7'b0000000;
      else if (br)                        e_ctl = 7'b1111111;
      else if (lu)                        e_ctl = 7'b0011101;
      else                                e_ctl = 7'b1111100;
      e_fa = ref_fwd(ex_rs1);
      e_fb = ref_fwd(ex_rs2);
   endtask

   task automatic model_clock();
      if (!rst_n) begin
         m_err = 0; m_waiting = 0; m_waited = 0; m_stall = 0; m_flush = 0;
         return;
      end
      if (!m_err && !e_ctl[6]) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
      if (e_ctl[1])            m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
      if (m_err) begin
      end else if (!m_waiting) begin
         if (mem_req && !mem_ack) begin
            m_waiting = 1;
            m_waited  = 0;
         end
      end else if (mem_ack) begin
         m_waiting = 0;
      end else begin
         m_waited++;
         if (m_waited >= TO) begin
            m_err     = 1;
            m_waiting = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      #2;
      expect_now();
      check("ctl", {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush},
            {25'd0, e_ctl});
      check("fwd_a", {30'd0, fwd_a}, {30'd0, e_fa});
      check("fwd_b", {30'd0, fwd_b}, {30'd0, e_fb});
      @(posedge clk);
      model_clock();
      #1;
      check("stall_cnt", {28'd0, stall_cnt}, m_stall);
      check("flush_cnt", {28'd0, flush_cnt}, m_flush);
      check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_rd_wren = 0; ex_is_load = 0; br = 0;
      mem_rd = 0; mem_rd_wren = 0; wb_rd = 0; wb_rd_wren = 0;
      mem_req = 0; mem_ack = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      step();
      rst_n = 1;
   endtask

   initial begin
      int err_run;
      idle();
      rst_n = 0;
      @(posedge clk);
      #1;
      // Reset state
      step();
      check("rst_stall", {28'd0, stall_cnt}, 0);
      check("rst_err", {31'd0, mem_err}, 0);
      rst_n = 1;

      // Load-use: lw x5 in EX, ID reads x5
      ex_is_load = 1; ex_rd = 5; ex_rd_wren = 1; id_rs1 = 5; id_rs1_use = 1;
      step();
      check("lu_stall_cnt", {28'd0, stall_cnt}, 1);
      idle();
      ex_rs1 = 5; wb_rd = 5; wb_rd_wren = 1;
      step();
      check("lu_fwd_a", {30'd0, fwd_a}, 2'b10);
      check("lu_stall_once", {28'd0, stall_cnt}, 1);

      // Forward priority and x0
      idle();
      ex_rs2 = 7; mem_rd = 7; wb_rd = 7; mem_rd_wren = 1; wb_rd_wren = 1;
      step();
      check("fwd_prio", {30'd0, fwd_b}, 2'b01);
      ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
      step();
      check("fwd_x0", {30'd0, fwd_b}, 2'b00);

      // Taken branch with a simultaneous load-use match
      do_reset();
      br = 1; ex_is_load = 1; ex_rd = 3; ex_rd_wren = 1; id_rs2 = 3; id_rs2_use = 1;
      step();
      check("br_flush_cnt", {28'd0, flush_cnt}, 1);
      check("br_no_stall", {28'd0, stall_cnt}, 0);

      // Memory wait of 3 cycles, then ack
      do_reset();
      mem_req = 1; mem_ack = 0;
      repeat (3) step();
      mem_ack = 1;
      step();
      check("mw_pc_en", {31'd0, pc_en}, 1);
      check("mw_stall_cnt", {28'd0, stall_cnt}, 3);
      step();
      check("mw_same_cycle", {28'd0, stall_cnt}, 3);

      // Timeout
      do_reset();
      mem_req = 1; mem_ack = 0;
      repeat (4) step();
      check("to_not_yet", {31'd0, mem_err}, 0);
      step();
      check("to_err", {31'd0, mem_err}, 1);
      mem_ack = 1;
      step();
      check("to_frozen", {31'd0, pc_en}, 0);
      do_reset();
      check("to_rst_err", {31'd0, mem_err}, 0);
      check("to_rst_stall", {28'd0, stall_cnt}, 0);
      step();

      // Redirect held through a 2-cycle memory wait
      do_reset();
      mem_req = 1; mem_ack = 0; br = 1;
      repeat (2) step();
      check("rw_no_flush", {28'd0, flush_cnt}, 0);
      mem_ack = 1;
      step();
      check("rw_flush_cnt", {28'd0, flush_cnt}, 1);

      // Stall counter saturation
      do_reset();
      ex_is_load = 1; ex_rd = 9; ex_rd_wren = 1; id_rs1 = 9; id_rs1_use = 1;
      repeat (20) step();
      check("sat_stall", {28'd0, stall_cnt}, CMAX);

      // Random traffic
      do_reset();
      err_run = 0;
      for (int i = 0; i < 400; i++) begin
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_rs1_use  = 1'($urandom_range(0, 1));
         id_rs2_use  = 1'($urandom_range(0, 1));
         ex_rs1      = 5'($urandom_range(0, 3));
         ex_rs2      = 5'($urandom_range(0, 3));
         ex_rd       = 5'($urandom_range(0, 3));
         ex_rd_wren  = 1'($urandom_range(0, 1));
         ex_is_load  = 1'($urandom_range(0, 1));
         br          = ($urandom_range(0, 5) == 0);
         mem_rd      = 5'($urandom_range(0, 3));
         mem_rd_wren = 1'($urandom_range(0, 1));
         wb_rd       = 5'($urandom_range(0, 3));
         wb_rd_wren  = 1'($urandom_range(0, 1));
         mem_req     = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
         mem_ack     = mem_req ? 1'($urandom_range(0, 1)) : 1'b0;
         err_run     = m_err ? err_run + 1 : 0;
         rst_n       = !(err_run >= 3 || $urandom_range(0, 99) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_hazard_ctrl
`default_nettype wire
